// File: rtl/prog_loader_if.sv
// ---------------------------------------------------------------------------
// prog_loader_if
//
// Groups the two buses of the program loader:
//   - byte stream in : in_valid, in_data, in_ready
//   - memory write   : we, w_addr, w_instr
//
// Modports:
//   master : the environment side (stream source + instruction memory).
//            Drives in_valid/in_data, observes in_ready and the write port.
//   slave  : the loader. Consumes the stream and drives the write port.
//
// Handshake: a byte moves when in_valid and in_ready are both high at a
// rising clk edge. The source keeps in_data stable while in_valid is high
// and no transfer has happened yet; the loader may hold in_ready low for
// as long as it likes, and in_valid low simply stalls the loader.
// ---------------------------------------------------------------------------
interface prog_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                      in_valid;
    logic [DATA_WIDTH-1:0]     in_data;
    logic                      in_ready;
    logic                      we;
    logic [ADDR_WIDTH-1:0]     w_addr;
    logic [2*DATA_WIDTH-1:0]   w_instr;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  we,
        input  w_addr,
        input  w_instr
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output we,
        output w_addr,
        output w_instr
    );
endinterface

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Receives a length-prefixed, checksummed program as a byte stream
// (L, L program bytes, C) and writes it into the byte-wide instruction
// memory as little-endian 16-bit words at addresses 0, 2, 4, ...
// An odd-length tail is padded in the high byte with PAD_BYTE (NOP).
// C must equal the wrapped sum of the program bytes; a mismatch sets err,
// but the words already written stay in memory.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : one-cycle load request, ignored while busy
//   bus         : prog_loader_if.slave (stream in + memory write port)
//   busy        : load in progress, core must not fetch
//   done        : one-cycle pulse when the load completes
//   err         : checksum mismatch of the last load, cleared by next start
//   dbg_state   : current FSM state encoding
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] PAD_BYTE   = 8'd40
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    prog_loader_if.slave        bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_LO   = 3'd2,
        S_HI   = 3'd3,
        S_WR   = 3'd4,
        S_CHK  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [DATA_WIDTH-1:0] ONE       = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = 2;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   remaining;
    logic [DATA_WIDTH-1:0]   sum;
    logic [DATA_WIDTH-1:0]   lo_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   w_addr_q;
    logic [2*DATA_WIDTH-1:0] w_instr_q;
    logic                    in_ready_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;
    logic                    xfer;

    assign xfer = bus.in_valid && in_ready_q;

    assign bus.in_ready = in_ready_q;
    assign bus.we       = we_q;
    assign bus.w_addr   = w_addr_q;
    assign bus.w_instr  = w_instr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign dbg_state    = state;

    // All outputs are registered: each branch sets them to the values the
    // next state presents, so in_ready/we/busy/done line up with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            remaining  <= '0;
            sum        <= '0;
            lo_q       <= '0;
            we_q       <= 1'b0;
            w_addr_q   <= '0;
            w_instr_q  <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        w_addr_q   <= '0;
                        sum        <= '0;
                        err_q      <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        remaining <= bus.in_data;
                        if (bus.in_data == '0) begin
                            state <= S_CHK;
                        end else begin
                            state <= S_LO;
                        end
                    end
                end
                S_LO: begin
                    if (xfer) begin
                        lo_q      <= bus.in_data;
                        sum       <= sum + bus.in_data;
                        remaining <= remaining - ONE;
                        if (remaining == ONE) begin
                            // Last byte of an odd-length program: pad high byte.
                            w_instr_q  <= {PAD_BYTE, bus.in_data};
                            we_q       <= 1'b1;
                            in_ready_q <= 1'b0;
                            state      <= S_WR;
                        end else begin
                            state <= S_HI;
                        end
                    end
                end
                S_HI: begin
                    if (xfer) begin
                        sum        <= sum + bus.in_data;
                        remaining  <= remaining - ONE;
                        w_instr_q  <= {bus.in_data, lo_q};
                        we_q       <= 1'b1;
                        in_ready_q <= 1'b0;
                        state      <= S_WR;
                    end
                end
                S_WR: begin
                    // The memory captures the word on the edge ending WR.
                    w_addr_q   <= w_addr_q + ADDR_STEP;
                    in_ready_q <= 1'b1;
                    if (remaining == '0) begin
                        state <= S_CHK;
                    end else begin
                        state <= S_LO;
                    end
                end
                S_CHK: begin
                    if (xfer) begin
                        err_q      <= (bus.in_data != sum);
                        in_ready_q <= 1'b0;
                        done_q     <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
